// File: rtl/hazard_control_unit_if.sv
// Hazard-controller bundle: ID/EX/MEM register info in, pipeline write enables,
// flush and control-reset lines out.
interface hazard_control_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 3
);
    logic              pcsrc_select_i;
    logic              memread_ex_i;
    logic              regwrite_ex_i;
    logic [ADDR_W-1:0] rd_ex_i;
    logic              regwrite_mem_i;
    logic [ADDR_W-1:0] rd_mem_i;
    logic [ADDR_W-1:0] rs_id_i;
    logic [ADDR_W-1:0] rt_id_i;
    logic              uses_rt_id_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              ifid_flush_o;
    logic              ctrl_reset_id_o;
    logic              ctrl_reset_ex_o;
    logic              ctrl_reset_mem_o;
    logic              stall_busy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output pcsrc_select_i, memread_ex_i, regwrite_ex_i, rd_ex_i,
               regwrite_mem_i, rd_mem_i, rs_id_i, rt_id_i, uses_rt_id_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, ctrl_reset_id_o,
               ctrl_reset_ex_o, ctrl_reset_mem_o, stall_busy_o, stall_cnt_o
    );

    modport slave (
        input  pcsrc_select_i, memread_ex_i, regwrite_ex_i, rd_ex_i,
               regwrite_mem_i, rd_mem_i, rs_id_i, rt_id_i, uses_rt_id_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, ctrl_reset_id_o,
               ctrl_reset_ex_o, ctrl_reset_mem_o, stall_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: multi-cycle load-use stall, optional RAW stall
// when forwarding is absent, and taken-branch flush with top priority.
module hazard_control_unit #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 3,
    parameter int FORWARDING = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_control_unit_if.slave hz
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             src_ex, src_mem, lu_hit, raw_hit, fsm_stall, stall;

    // Register 0 is hard-wired zero, so it never forms a dependency.
    function automatic logic src_match(input logic [ADDR_W-1:0] dst,
                                       input logic [ADDR_W-1:0] rs,
                                       input logic [ADDR_W-1:0] rt,
                                       input logic              use_rt);
        return ((rs != '0) && (rs == dst)) ||
               (use_rt && (rt != '0) && (rt == dst));
    endfunction

    always_comb begin
        src_ex  = src_match(hz.rd_ex_i,  hz.rs_id_i, hz.rt_id_i, hz.uses_rt_id_i);
        src_mem = src_match(hz.rd_mem_i, hz.rs_id_i, hz.rt_id_i, hz.uses_rt_id_i);
        lu_hit  = hz.memread_ex_i && src_ex;
        raw_hit = (FORWARDING == 0) &&
                  ((hz.regwrite_ex_i && src_ex) || (hz.regwrite_mem_i && src_mem));
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fsm_stall = 1'b0;
        if (hz.pcsrc_select_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu_hit) begin
                        fsm_stall = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CNT_W'(LOAD_STALL - 1);
                        end
                    end
                end
                STALL: begin
                    // EX holds a bubble here, so lu_hit is meaningless until IDLE.
                    fsm_stall = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign stall = fsm_stall || raw_hit;

    always_comb begin
        hz.pc_write_o       = 1'b1;
        hz.ifid_write_o     = 1'b1;
        hz.ifid_flush_o     = 1'b0;
        hz.ctrl_reset_id_o  = 1'b0;
        hz.ctrl_reset_ex_o  = 1'b0;
        hz.ctrl_reset_mem_o = 1'b0;
        if (hz.pcsrc_select_i) begin
            hz.ifid_flush_o    = 1'b1;
            hz.ctrl_reset_id_o = 1'b1;
            hz.ctrl_reset_ex_o = 1'b1;
        end else if (stall) begin
            hz.pc_write_o      = 1'b0;
            hz.ifid_write_o    = 1'b0;
            hz.ctrl_reset_id_o = 1'b1;
        end
    end

    assign hz.stall_busy_o = (state == STALL);
    assign hz.stall_cnt_o  = cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three configurations (LS=3/fwd, LS=1/fwd,
// LS=2/no-fwd) driven in parallel and checked against a remaining-bubbles model.
module tb_hazard_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pcsrc = 1'b0, memread_ex = 1'b0, regwrite_ex = 1'b0;
    logic       regwrite_mem = 1'b0, uses_rt = 1'b0;
    logic [4:0] rd_ex = '0, rd_mem = '0, rs_id = '0, rt_id = '0;

    int         checks = 0;
    int         passes = 0;
    int         rem [3] = '{0, 0, 0};
    int         nxt [3];
    logic [9:0] exp_o [3];
    logic [9:0] obs [3];

    always #5 clk = ~clk;

    hazard_control_unit_if #(.ADDR_W(5), .CNT_W(3)) hif [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hif[g].pcsrc_select_i = pcsrc;
        assign hif[g].memread_ex_i   = memread_ex;
        assign hif[g].regwrite_ex_i  = regwrite_ex;
        assign hif[g].rd_ex_i        = rd_ex;
        assign hif[g].regwrite_mem_i = regwrite_mem;
        assign hif[g].rd_mem_i       = rd_mem;
        assign hif[g].rs_id_i        = rs_id;
        assign hif[g].rt_id_i        = rt_id;
        assign hif[g].uses_rt_id_i   = uses_rt;
        assign obs[g] = {hif[g].pc_write_o, hif[g].ifid_write_o, hif[g].ifid_flush_o,
                         hif[g].ctrl_reset_id_o, hif[g].ctrl_reset_ex_o,
                         hif[g].ctrl_reset_mem_o, hif[g].stall_busy_o, hif[g].stall_cnt_o};
        hazard_control_unit #(
            .ADDR_W(5),
            .LOAD_STALL(g == 0 ? 3 : (g == 1 ? 1 : 2)),
            .CNT_W(3),
            .FORWARDING(g == 2 ? 0 : 1)
        ) dut (
            .clk_i(clk),
            .rst_i(rst_n),
            .hz(hif[g])
        );
    end

    function automatic int ls_of(int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic bit src_hit(logic [4:0] d);
        return (rs_id != 0 && rs_id == d) || (uses_rt && rt_id != 0 && rt_id == d);
    endfunction

    // Output vector {pc,ifid,flush,rst_id,rst_ex,rst_mem,busy,cnt[2:0]} for
    // config i, given how many extra bubbles it still owes.
    function automatic logic [9:0] model(int i);
        bit lu, raw, stall;
        bit busy = rem[i] > 0;
        logic [2:0] c = 3'(rem[i]);
        if (pcsrc) return {6'b111110, busy, c};
        lu    = memread_ex && src_hit(rd_ex);
        raw   = (i == 2) && ((regwrite_ex && src_hit(rd_ex)) || (regwrite_mem && src_hit(rd_mem)));
        stall = busy || lu || raw;
        return {!stall, !stall, 1'b0, stall, 2'b00, busy, c};
    endfunction

    function automatic int next_rem(int i);
        if (!rst_n || pcsrc) return 0;
        if (rem[i] > 0) return rem[i] - 1;
        if (memread_ex && src_hit(rd_ex)) return ls_of(i) - 1;
        return 0;
    endfunction

    task automatic set_in(logic br, logic mr, logic rwe, logic [4:0] rde,
                          logic rwm, logic [4:0] rdm, logic [4:0] rs, logic [4:0] rt, logic ur);
        pcsrc = br; memread_ex = mr; regwrite_ex = rwe; rd_ex = rde;
        regwrite_mem = rwm; rd_mem = rdm; rs_id = rs; rt_id = rt; uses_rt = ur;
    endtask

    task automatic settle();
        #4;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) rem[i] = 0;
            exp_o[i] = model(i);
        end
    endtask

    task automatic advance();
        for (int i = 0; i < 3; i++) nxt[i] = next_rem(i);
        @(posedge clk);
        for (int i = 0; i < 3; i++) rem[i] = nxt[i];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== 10'b11_0000_0000) $display("FAIL reset dut%0d got %b exp %b", i, obs[i], 10'b11_0000_0000);
            else passes++;
        end
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        // hit at T, then ID input cleared (EX holds a bubble); 4 cycles observed
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_in(0, 1, 1, 8, 0, 0, 8, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_o[i]) $display("FAIL load_use c%0d dut%0d got %b exp %b", c, i, obs[i], exp_o[i]);
                else passes++;
            end
            checks++;
            if (hif[0].pc_write_o !== (c == 3)) $display("FAIL ls3_pc_write c%0d got %b exp %b", c, hif[0].pc_write_o, c == 3);
            else passes++;
            checks++;
            if (hif[0].stall_cnt_o !== 3'((c == 1) ? 2 : ((c == 2) ? 1 : 0)))
                $display("FAIL ls3_cnt c%0d got %0d", c, hif[0].stall_cnt_o);
            else passes++;
            checks++;
            if (hif[1].stall_busy_o !== 1'b0) $display("FAIL ls1_busy c%0d got %b exp 0", c, hif[1].stall_busy_o);
            else passes++;
            advance();
        end
    endtask

    task automatic test_reg0_and_rt();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) set_in(0, 1, 1, 0, 0, 0, 0, 0, 1);
            else        set_in(0, 1, 1, 6, 0, 0, 1, 6, 0);
            settle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_o[i] || obs[i][9] !== 1'b1)
                    $display("FAIL no_hazard c%0d dut%0d got %b exp %b", c, i, obs[i], exp_o[i]);
                else passes++;
            end
            advance();
        end
    endtask

    task automatic test_branch();
        // c0 hit, c1 branch mid-stall, c2 idle; then hit+branch together, then idle
        for (int c = 0; c < 5; c++) begin
            case (c)
                0, 3:    set_in(c == 3, 1, 1, 9, 0, 0, 9, 0, 0);
                1:       set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            settle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_o[i]) $display("FAIL branch c%0d dut%0d got %b exp %b", c, i, obs[i], exp_o[i]);
                else passes++;
            end
            if (c == 1) begin
                checks++;
                if (obs[0][9:4] !== 6'b111110) $display("FAIL branch_flush got %b exp 111110", obs[0][9:4]);
                else passes++;
            end
            if (c == 2 || c == 4) begin
                checks++;
                if ({hif[0].stall_busy_o, hif[0].stall_cnt_o} !== 4'b0)
                    $display("FAIL branch_idle c%0d got %b exp 0000", c, {hif[0].stall_busy_o, hif[0].stall_cnt_o});
                else passes++;
            end
            advance();
        end
    endtask

    task automatic test_no_forwarding();
        set_in(0, 0, 0, 0, 1, 5, 0, 5, 1);
        settle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_o[i]) $display("FAIL raw dut%0d got %b exp %b", i, obs[i], exp_o[i]);
            else passes++;
        end
        checks++;
        if ({hif[2].pc_write_o, hif[0].pc_write_o} !== 2'b01)
            $display("FAIL raw_pc got %b exp 01", {hif[2].pc_write_o, hif[0].pc_write_o});
        else passes++;
        advance();
    endtask

    task automatic test_reset_mid_stall();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) set_in(0, 1, 0, 7, 0, 0, 0, 7, 1);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (c == 1) rst_n = 1'b0;
            if (c == 2) rst_n = 1'b1;
            settle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_o[i]) $display("FAIL rst_mid c%0d dut%0d got %b exp %b", c, i, obs[i], exp_o[i]);
                else passes++;
            end
            if (c > 0) begin
                checks++;
                if ({hif[0].pc_write_o, hif[0].stall_busy_o, hif[0].stall_cnt_o} !== 5'b10000)
                    $display("FAIL rst_mid_ls3 c%0d got %b exp 10000", c,
                             {hif[0].pc_write_o, hif[0].stall_busy_o, hif[0].stall_cnt_o});
                else passes++;
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            set_in($urandom_range(0, 11) == 0, 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
            settle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== exp_o[i]) $display("FAIL random c%0d dut%0d got %b exp %b", c, i, obs[i], exp_o[i]);
                else passes++;
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_reg0_and_rt();
        test_branch();
        test_no_forwarding();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
